// File: rtl/cnn_result_decoder.sv
// CNN result decoder: scans a stream of per-class scores (one or more lanes
// per input word), tracks the highest score and its class index, and hands
// a tagged result word {seq, class, max_score} to a stalling consumer.
module cnn_result_decoder #(
   parameter int NUM_CLASSES     = 10,
   parameter int VALUE_BITS      = 8,
   parameter int VALUES_PER_WORD = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] in_data,
   input  logic        in_valid,
   output logic        upstream_stall,
   output logic [31:0] out_data,
   output logic        out_valid,
   input  logic        downstream_stall
);

   typedef enum logic {COLLECT = 1'b0, EMIT = 1'b1} state_t;

   state_t      state_q;
   logic [7:0]  idx_q;
   logic [15:0] best_score_q;
   logic [7:0]  best_cls_q;
   logic [7:0]  seq_q;
   logic [31:0] out_data_q;
   logic        out_valid_q;
   logic        stall_q;

   logic        accept;
   logic [15:0] best_score_d;
   logic [7:0]  best_cls_d;
   logic [8:0]  idx_d;
   logic [8:0]  remain;

   // Lanes above VALUES_PER_WORD*VALUE_BITS carry no scores.
   logic        unused_in_bits;
   assign unused_in_bits = ^in_data;

   // Stall is a pure register, so accept never depends combinationally on it
   // beyond the registered state.
   assign accept = in_valid && !stall_q;

   // Scan the lanes of the current word in class order; strict compare keeps
   // the lowest class index on ties, and lanes past the last class are ignored.
   always_comb begin
      best_score_d = best_score_q;
      best_cls_d   = best_cls_q;
      for (int k = 0; k < VALUES_PER_WORD; k++) begin
         logic [8:0]  lane_idx;
         logic [15:0] lane_val;
         lane_idx = {1'b0, idx_q} + 9'(k);
         lane_val = 16'(in_data[k*VALUE_BITS +: VALUE_BITS]);
         if ((lane_idx < 9'(NUM_CLASSES)) && (lane_val > best_score_d)) begin
            best_score_d = lane_val;
            best_cls_d   = lane_idx[7:0];
         end
      end
      remain = 9'(NUM_CLASSES) - {1'b0, idx_q};
      if (remain < 9'(VALUES_PER_WORD)) begin
         idx_d = {1'b0, idx_q} + remain;
      end else begin
         idx_d = {1'b0, idx_q} + 9'(VALUES_PER_WORD);
      end
   end

   // COLLECT/EMIT state machine with registered handshake outputs.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q      <= COLLECT;
         idx_q        <= '0;
         best_score_q <= '0;
         best_cls_q   <= '0;
         seq_q        <= '0;
         out_data_q   <= '0;
         out_valid_q  <= 1'b0;
         stall_q      <= 1'b0;
      end else begin
         case (state_q)
            COLLECT: begin
               if (accept) begin
                  best_score_q <= best_score_d;
                  best_cls_q   <= best_cls_d;
                  idx_q        <= idx_d[7:0];
                  if (idx_d == 9'(NUM_CLASSES)) begin
                     state_q     <= EMIT;
                     stall_q     <= 1'b1;
                     out_valid_q <= 1'b1;
                     out_data_q  <= {seq_q, best_cls_d, best_score_d};
                  end
               end
            end
            EMIT: begin
               if (!downstream_stall) begin
                  state_q      <= COLLECT;
                  stall_q      <= 1'b0;
                  out_valid_q  <= 1'b0;
                  idx_q        <= '0;
                  best_score_q <= '0;
                  best_cls_q   <= '0;
                  seq_q        <= seq_q + 8'd1;
               end
            end
            default: begin
               state_q <= COLLECT;
            end
         endcase
      end
   end

   assign upstream_stall = stall_q;
   assign out_valid      = out_valid_q;
   assign out_data       = out_data_q;

endmodule

// File: tb/tb_cnn_result_decoder.sv
// Directed bench for cnn_result_decoder: a default-parameter instance driven
// from a vector table plus handshake/reset sequences, and a four-lane
// instance checking packed words with a partial final word.
module tb_cnn_result_decoder;

   logic        clock;
   logic        reset;
   logic [31:0] in_data;
   logic        in_valid;
   logic        upstream_stall;
   logic [31:0] out_data;
   logic        out_valid;
   logic        downstream_stall;

   logic [31:0] b_in_data;
   logic        b_in_valid;
   logic        b_upstream_stall;
   logic [31:0] b_out_data;
   logic        b_out_valid;
   logic        b_downstream_stall;

   int n_cmp;
   int n_fail;
   logic [7:0] exp_seq;
   logic [7:0] exp_seq_b;

   cnn_result_decoder dut_a (
      .clock            (clock),
      .reset            (reset),
      .in_data          (in_data),
      .in_valid         (in_valid),
      .upstream_stall   (upstream_stall),
      .out_data         (out_data),
      .out_valid        (out_valid),
      .downstream_stall (downstream_stall)
   );

   cnn_result_decoder #(
      .NUM_CLASSES     (10),
      .VALUE_BITS      (8),
      .VALUES_PER_WORD (4)
   ) dut_b (
      .clock            (clock),
      .reset            (reset),
      .in_data          (b_in_data),
      .in_valid         (b_in_valid),
      .upstream_stall   (b_upstream_stall),
      .out_data         (b_out_data),
      .out_valid        (b_out_valid),
      .downstream_stall (b_downstream_stall)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   typedef struct {
      logic [79:0] sc;     // class i score at sc[i*8 +: 8]
      logic [7:0]  cls;
      logic [15:0] score;
      int          hold;   // consumer stall cycles after out_valid
   } vec_t;

   typedef struct {
      logic [95:0] words;  // word j at words[j*32 +: 32]
      logic [7:0]  cls;
      logic [15:0] score;
   } bvec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      exp_seq   = 8'd0;
      exp_seq_b = 8'd0;
   endtask

   // Drive ten scores on consecutive cycles; returns at the negedge after the
   // final word was accepted, with in_valid low.
   task automatic feed_words(input logic [79:0] sc);
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         if (i == 0) check("stall_before_image", {31'd0, upstream_stall}, 32'd0);
         if (i == 9) check("no_valid_before_last", {31'd0, out_valid}, 32'd0);
         in_valid = 1'b1;
         in_data  = {24'd0, sc[i*8 +: 8]};
      end
      @(negedge clock);
      in_valid = 1'b0;
      in_data  = 32'd0;
   endtask

   task automatic run_image(input vec_t v);
      logic [31:0] exp_word;
      feed_words(v.sc);
      exp_word = {exp_seq, v.cls, v.score};
      check("out_valid_latency", {31'd0, out_valid}, 32'd1);
      check("stall_in_emit", {31'd0, upstream_stall}, 32'd1);
      check("result", out_data, exp_word);
      downstream_stall = (v.hold > 0);
      for (int j = 0; j < v.hold; j++) begin
         in_valid = 1'b1;
         in_data  = 32'h0000_00FF;
         @(negedge clock);
         check("hold_valid", {31'd0, out_valid}, 32'd1);
         check("hold_stall", {31'd0, upstream_stall}, 32'd1);
         check("hold_data", out_data, exp_word);
         if (j == v.hold - 1) downstream_stall = 1'b0;
      end
      in_valid = 1'b0;
      in_data  = 32'd0;
      @(negedge clock);
      check("released_valid", {31'd0, out_valid}, 32'd0);
      check("released_stall", {31'd0, upstream_stall}, 32'd0);
      exp_seq = exp_seq + 8'd1;
   endtask

   task automatic run_b(input bvec_t v);
      for (int j = 0; j < 3; j++) begin
         @(negedge clock);
         check("b_stall_before_word", {31'd0, b_upstream_stall}, 32'd0);
         if (j == 2) check("b_no_valid_early", {31'd0, b_out_valid}, 32'd0);
         b_in_valid = 1'b1;
         b_in_data  = v.words[j*32 +: 32];
      end
      @(negedge clock);
      b_in_valid = 1'b0;
      b_in_data  = 32'd0;
      check("b_out_valid", {31'd0, b_out_valid}, 32'd1);
      check("b_result", b_out_data, {exp_seq_b, v.cls, v.score});
      @(negedge clock);
      check("b_released", {31'd0, b_out_valid}, 32'd0);
      exp_seq_b = exp_seq_b + 8'd1;
   endtask

   function automatic logic [7:0] stream_score(input int img, input int cls);
      if (cls == img % 10) return 8'd200;
      return 8'(cls + img % 50);
   endfunction

   vec_t  vecs [6];
   bvec_t bvecs [2];

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      reset = 1'b1;
      in_data = 32'd0; in_valid = 1'b0; downstream_stall = 1'b0;
      b_in_data = 32'd0; b_in_valid = 1'b0; b_downstream_stall = 1'b0;
      exp_seq = 8'd0; exp_seq_b = 8'd0;

      vecs[0] = '{sc: 80'h06_05_04_09_02_07_00_01_09_03, cls: 8'd1, score: 16'h0009, hold: 0};
      vecs[1] = '{sc: 80'h00_00_00_00_00_00_00_00_00_00, cls: 8'd0, score: 16'h0000, hold: 0};
      vecs[2] = '{sc: 80'hFF_FF_FF_FF_FF_FF_FF_FF_FF_FF, cls: 8'd0, score: 16'h00FF, hold: 5};
      vecs[3] = '{sc: 80'h09_08_07_06_05_04_03_02_01_00, cls: 8'd9, score: 16'h0009, hold: 1};
      vecs[4] = '{sc: 80'h80_10_20_80_00_00_00_00_00_00, cls: 8'd6, score: 16'h0080, hold: 0};
      vecs[5] = '{sc: 80'h01_01_01_01_01_01_01_01_01_FE, cls: 8'd0, score: 16'h00FE, hold: 2};

      bvecs[0] = '{words: {32'hEE0008AA, 32'h05FF0607, 32'h01020304}, cls: 8'd6, score: 16'h00FF};
      bvecs[1] = '{words: {32'hEE000910, 32'h05060708, 32'h01020304}, cls: 8'd8, score: 16'h0010};

      do_reset();
      check("reset_out_valid", {31'd0, out_valid}, 32'd0);
      check("reset_stall", {31'd0, upstream_stall}, 32'd0);
      check("reset_out_data", out_data, 32'd0);
      check("b_reset_out_data", b_out_data, 32'd0);

      for (int i = 0; i < 2; i++) run_b(bvecs[i]);

      for (int i = 0; i < 6; i++) run_image(vecs[i]);

      // Reset after four words, with a word offered in the reset cycle.
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         in_valid = 1'b1;
         in_data  = 32'h0000_00FE;
      end
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      in_valid = 1'b0;
      in_data  = 32'd0;
      exp_seq = 8'd0;
      exp_seq_b = 8'd0;
      check("midreset_valid", {31'd0, out_valid}, 32'd0);
      check("midreset_stall", {31'd0, upstream_stall}, 32'd0);
      check("midreset_data", out_data, 32'd0);
      run_image(vecs[0]);

      // Reset while a result is pending drops it without advancing seq.
      feed_words(vecs[3].sc);
      check("pending_valid", {31'd0, out_valid}, 32'd1);
      downstream_stall = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      downstream_stall = 1'b0;
      exp_seq = 8'd0;
      exp_seq_b = 8'd0;
      check("emitreset_valid", {31'd0, out_valid}, 32'd0);
      check("emitreset_data", out_data, 32'd0);
      run_image(vecs[0]);

      // 257 back-to-back images; words offered while stalled would win if taken.
      do_reset();
      begin
         int n_img, feed_img, word_i, cyc, last_cyc;
         n_img = 0; feed_img = 0; word_i = 0; cyc = 0; last_cyc = 0;
         while (n_img < 257 && cyc < 4000) begin
            @(negedge clock);
            cyc++;
            if (out_valid) begin
               check("stream_result", out_data,
                     {exp_seq, 8'(n_img % 10), 16'd200});
               if (n_img > 0) check("stream_period", cyc - last_cyc, 32'd11);
               last_cyc = cyc;
               exp_seq = exp_seq + 8'd1;
               n_img++;
            end
            in_valid = 1'b1;
            if (!upstream_stall) begin
               in_data = {24'd0, stream_score(feed_img, word_i)};
               word_i++;
               if (word_i == 10) begin
                  word_i = 0;
                  feed_img++;
               end
            end else begin
               in_data = 32'h0000_00FF;
            end
         end
         in_valid = 1'b0;
         check("stream_images", n_img, 32'd257);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
